// File: rtl/discrete_range_sequencer.sv
// discrete_range_sequencer: draws a uniform value from a randomly chosen [start:end] entry of the discrete values table
module discrete_range_sequencer #(
  parameter int MAX_BIT_WIDTH_OF_INTEGER_VARIABLE = 8,
  parameter int MAX_BIT_WIDTH_OF_VARIABLES_INDEX  = 8,
  parameter int MAX_BIT_WIDTH_OF_DISCRETE_CHOICES = 4
) (
  input  logic                                        in_clock,
  input  logic                                        in_reset,
  input  logic                                        in_request,
  output logic                                        out_ready,
  input  logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0]  in_variable_index,
  input  logic [MAX_BIT_WIDTH_OF_DISCRETE_CHOICES:0]   in_number_of_choices,
  input  logic [2*MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_random,
  output logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0]  out_table_variable_index,
  output logic [MAX_BIT_WIDTH_OF_DISCRETE_CHOICES-1:0] out_table_index_of_the_discrete_value,
  input  logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0]  in_table_start,
  input  logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0]  in_table_end,
  output logic                                        out_valid,
  output logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0]  out_value,
  output logic [MAX_BIT_WIDTH_OF_DISCRETE_CHOICES-1:0] out_choice,
  output logic                                        out_error
);
  localparam int W = MAX_BIT_WIDTH_OF_INTEGER_VARIABLE;
  localparam int C = MAX_BIT_WIDTH_OF_DISCRETE_CHOICES;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, COMPUTE, DONE} state_t;
  state_t state;
  logic [W-1:0] rand_lo, start_r, scaled;
  logic [W:0] span1, span_next;
  logic err;
  logic [W+C:0] choice_prod;
  logic [2*W:0] value_prod;
  logic [C-1:0] choice_next;
  assign choice_prod = {{(C+1){1'b0}}, in_random[2*W-1:W]} * {{W{1'b0}}, in_number_of_choices};
  assign choice_next = C'(choice_prod >> W);
  assign span_next = {1'b0, in_table_end} - {1'b0, in_table_start} + {{W{1'b0}}, 1'b1};
  // span1 can be 2**W, so the product needs 2W+1 bits before scaling back down
  assign value_prod = {{(W+1){1'b0}}, rand_lo} * {{W{1'b0}}, span1};
  assign scaled = W'(value_prod >> W);
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state <= IDLE;
      out_ready <= 1'b1;
      out_valid <= 1'b0;
      out_value <= '0;
      out_choice <= '0;
      out_error <= 1'b0;
      out_table_variable_index <= '0;
      out_table_index_of_the_discrete_value <= '0;
      rand_lo <= '0;
      start_r <= '0;
      span1 <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_request && out_ready) begin
          out_ready <= 1'b0;
          if (in_number_of_choices == '0) state <= DONE;
          else begin
            out_table_variable_index <= in_variable_index;
            out_table_index_of_the_discrete_value <= choice_next;
            rand_lo <= in_random[W-1:0];
            state <= ADDR;
          end
        end
        ADDR: state <= DATA;
        DATA: begin
          start_r <= in_table_start;
          span1 <= span_next;
          err <= in_table_end < in_table_start;
          state <= COMPUTE;
        end
        COMPUTE: begin
          out_value <= err ? start_r : start_r + scaled;
          out_choice <= out_table_index_of_the_discrete_value;
          out_error <= err;
          out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          // zero-choices draws arrive here with out_valid low and publish their error result one cycle later
          if (out_valid) begin
            out_valid <= 1'b0;
            out_ready <= 1'b1;
            state <= IDLE;
          end else begin
            out_valid <= 1'b1;
            out_value <= '0;
            out_choice <= '0;
            out_error <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_discrete_range_sequencer.sv
// tb_discrete_range_sequencer: directed draws checked by a scoreboard monitor against hand-computed results
module tb_discrete_range_sequencer;
  logic clk = 1'b0, rst = 1'b1, in_request = 1'b0;
  logic [7:0] in_variable_index = '0;
  logic [4:0] in_number_of_choices = '0;
  logic [15:0] in_random = '0;
  logic [7:0] addr_v, in_table_start, in_table_end, out_value;
  logic [3:0] addr_c, out_choice;
  logic out_ready, out_valid, out_error;
  logic [7:0] ts [0:4095];
  logic [7:0] te [0:4095];
  int cyc = 0, errors = 0, checks = 0;
  typedef struct {logic [7:0] v; logic [3:0] c; logic e; int acc; int lat;} exp_t;
  exp_t q[$];

  discrete_range_sequencer dut (
    .in_clock(clk), .in_reset(rst), .in_request(in_request), .out_ready(out_ready),
    .in_variable_index(in_variable_index), .in_number_of_choices(in_number_of_choices),
    .in_random(in_random), .out_table_variable_index(addr_v),
    .out_table_index_of_the_discrete_value(addr_c), .in_table_start(in_table_start),
    .in_table_end(in_table_end), .out_valid(out_valid), .out_value(out_value),
    .out_choice(out_choice), .out_error(out_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    in_table_start <= ts[{addr_v, addr_c}];
    in_table_end <= te[{addr_v, addr_c}];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) if (out_valid) begin
    if (q.size() == 0) chk("unexpected_valid", 32'(q.size()), 1);
    else begin
      exp_t e;
      e = q.pop_front();
      chk("value", 32'(out_value), 32'(e.v));
      chk("choice", 32'(out_choice), 32'(e.c));
      chk("error", 32'(out_error), 32'(e.e));
      chk("latency", 32'(cyc - e.acc), 32'(e.lat));
    end
  end

  task automatic wait_ready;
    int k = 0;
    while (!out_ready && k < 30) begin @(negedge clk); k++; end
    if (!out_ready) chk("ready_timeout", 32'(out_ready), 1);
  endtask

  task automatic draw(input [7:0] v, input [4:0] n, input [15:0] r,
                      input [7:0] ev, input [3:0] ec, input ee, input int lat);
    @(negedge clk);
    wait_ready;
    in_variable_index = v; in_number_of_choices = n; in_random = r; in_request = 1'b1;
    q.push_back('{ev, ec, ee, cyc + 1, lat});
    @(negedge clk);
    in_request = 1'b0;
  endtask

  task automatic drain;
    int k = 0;
    while (q.size() > 0 && k < 40) begin @(negedge clk); k++; end
    chk("drain", 32'(q.size()), 0);
    wait_ready;
  endtask

  task automatic chk_reset_state;
    chk("rst_ready", 32'(out_ready), 1);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_value", 32'(out_value), 0);
    chk("rst_choice", 32'(out_choice), 0);
    chk("rst_error", 32'(out_error), 0);
    chk("rst_addr_v", 32'(addr_v), 0);
    chk("rst_addr_c", 32'(addr_c), 0);
  endtask

  initial begin
    int a0;
    for (int i = 0; i < 4096; i++) begin ts[i] = 8'd0; te[i] = 8'd0; end
    ts[2*16+3] = 8'd10;  te[2*16+3] = 8'd20;
    ts[5*16+0] = 8'd7;   te[5*16+0] = 8'd7;
    ts[1*16+15] = 8'd0;  te[1*16+15] = 8'd255;
    ts[3*16+1] = 8'd50;  te[3*16+1] = 8'd40;
    #12;
    chk_reset_state;
    @(negedge clk); rst = 1'b0;
    draw(8'd2, 5'd4, 16'hC080, 8'd15, 4'd3, 1'b0, 3);
    drain;
    chk("t1_addr_v", 32'(addr_v), 2);
    chk("t1_addr_c", 32'(addr_c), 3);
    draw(8'd5, 5'd1, 16'h12FF, 8'd7, 4'd0, 1'b0, 3);
    drain;
    draw(8'd9, 5'd0, 16'hABCD, 8'd0, 4'd0, 1'b1, 1);
    drain;
    chk("t3_addr_v", 32'(addr_v), 5);
    chk("t3_addr_c", 32'(addr_c), 0);
    draw(8'd1, 5'd16, 16'hFFFF, 8'd255, 4'd15, 1'b0, 3);
    draw(8'd1, 5'd16, 16'hFF00, 8'd0, 4'd15, 1'b0, 3);
    draw(8'd3, 5'd2, 16'h8000, 8'd50, 4'd1, 1'b1, 3);
    drain;
    draw(8'd9, 5'd0, 16'h0000, 8'd0, 4'd0, 1'b1, 1);
    draw(8'd2, 5'd4, 16'hC080, 8'd15, 4'd3, 1'b0, 3);
    drain;
    // request held high: accepts must land exactly 5 cycles apart
    @(negedge clk);
    in_variable_index = 8'd2; in_number_of_choices = 5'd4; in_random = 16'hC080; in_request = 1'b1;
    a0 = cyc + 1;
    for (int i = 0; i < 3; i++) q.push_back('{8'd15, 4'd3, 1'b0, a0 + 5*i, 3});
    repeat (11) @(negedge clk);
    in_request = 1'b0;
    drain;
    // reset pulse while the table data is being captured
    in_variable_index = 8'd3; in_number_of_choices = 5'd2; in_random = 16'h8000; in_request = 1'b1;
    @(negedge clk);
    in_request = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_state;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk_reset_state;
    draw(8'd5, 5'd1, 16'h12FF, 8'd7, 4'd0, 1'b0, 3);
    drain;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
